mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 16-bit system RAM (hi bank = even byte, lo bank = odd byte) among three requesters:
//  video fetch, CPU and a DMA/loader port. One access issued per clk; synchronous RAM, read data 1 cycle later.
//  Sits in top between cpu/video/dma and mem; owns byte-lane steering and CPU starvation protection.
// PARAMETERS
//  AW            15  word-address width (byte address = AW+1 bits)
//  STARVE_LIMIT  4   consecutive cycles a pending CPU access may lose to video before it gets priority
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  vid_req      in   1   video word fetch request (single-cycle, no hold)
//  vid_addr     in   AW  video word address
//  vid_gnt      out  1   video request issued this cycle
//  vid_rvalid   out  1   vid_rdata valid (cycle after vid_gnt)
//  vid_rdata    out  16  video read word {hi,lo}
//  cpu_en       in   1   CPU access request, held until cpu_ready
//  cpu_wr       in   1   1=write
//  cpu_wide     in   1   1=16-bit, 0=byte
//  cpu_addr     in   AW+1 CPU byte address
//  cpu_din      in   16  CPU write data (byte writes use [7:0])
//  cpu_dout     out  16  CPU read data (byte reads zero-extended in [7:0])
//  cpu_ready    out  1   1-cycle pulse: CPU access complete
//  dma_req      in   1   DMA request, held until dma_gnt
//  dma_wr       in   1   1=write
//  dma_be       in   2   byte enables {hi,lo}
//  dma_addr     in   AW  DMA word address
//  dma_wdata    in   16  DMA write word
//  dma_gnt      out  1   DMA access issued this cycle
//  dma_rvalid   out  1   dma_rdata valid (cycle after read grant)
//  dma_rdata    out  16  DMA read word
//  mem_en       out  1   RAM access strobe
//  mem_we       out  2   RAM byte write enables {hi,lo}
//  mem_addr     out  AW  RAM word address
//  mem_wdata    out  16  RAM write word
//  mem_rdata    in   16  RAM read word (valid cycle after mem_en)
// BEHAVIOUR
//  - Reset: all outputs 0; starve_cnt=0; cpu_busy=0; resp_owner=NONE. Responses in flight at reset are dropped.
//  - Grant per cycle (combinational on inputs+state, outputs registered to RAM same cycle): priority
//    video > CPU > DMA, except when starve_cnt==STARVE_LIMIT: CPU > video > DMA; video loses that slot (vid_gnt=0, fetch not retried).
//  - CPU eligible only when cpu_en && !cpu_busy. On grant: cpu_busy=1; next cycle cpu_ready=1, cpu_busy=0.
//    cpu_en still high the cycle after cpu_ready = new access (eligible that same cycle).
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) each cycle CPU eligible but not granted; cleared on CPU grant or !cpu_en.
//  - resp_owner (NONE/VID/CPU/DMA) registers grantee of each read; next cycle drives matching rvalid/cpu_ready and data.
//    Writes: CPU still gets cpu_ready next cycle; video/DMA write gives no rvalid.
//  - Lane steering, CPU: wide -> addr[0] ignored, mem_we=wr?2'b11:0, dout=mem_rdata.
//    byte even -> hi lane: mem_we=2'b10, wdata={din[7:0],8'h00}, dout={8'h00,rdata[15:8]}; byte odd -> lo lane, 2'b01.
//  - DMA writes use dma_be directly; dma_be==0 write still consumes slot, mem_en=1, mem_we=0.
//  - Same-cycle video read and CPU write to same word: serialized by priority; the later access sees the earlier.
//  - Idle cycle: mem_en=0, mem_we=0; mem_addr/wdata hold last value.
//  - Latency: grant->data exactly 1 cycle for every port; throughput 1 access/cycle.
// STRUCTURE
//  - mem_arb_defs.vh: owner encodings OWN_NONE/VID/CPU/DMA (2 bits), lane mask constants.
//  - Sub-module byte_lane_steer: combinational CPU wide/byte -> mem_we, mem_wdata, and rdata->cpu_dout extraction.
//  - mem_arbiter: grant logic, starve_cnt, cpu_busy, resp_owner pipeline register, RAM port mux.
// TESTING (behavioural RAM model, 1-cycle read)
//  1 CPU wide write 0x1234 @0xF000, then wide read -> mem_we=2'b11, cpu_ready 1 cycle after each grant, dout=0x1234.
//  2 Byte write 0xAB @0xF001 then byte read @0xF000/0xF001 -> mem_we=2'b01; reads 0x0012, 0x00AB.
//  3 vid_req every cycle + cpu_en held -> CPU granted on 5th cycle (STARVE_LIMIT=4), vid_gnt=0 that cycle only.
//  4 vid_req, cpu_en, dma_req all in cycle 0 -> vid_gnt c0, CPU c1, dma_gnt c2 (others idle).
//  5 DMA write be=2'b10 0xFFFF over 0x1234 -> word reads 0xFF34; DMA read rvalid exactly 1 cycle after gnt.
//  6 rst_n low the cycle after a CPU read grant -> cpu_ready never pulses; all outputs 0; normal op after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - response owner encodings, byte-lane masks and lane helper
package mem_arbiter_pkg;

   // Who owns the RAM response arriving next cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_DMA  = 2'd3
   } owner_e;

   // Byte-lane masks {hi,lo}; hi = even byte, lo = odd byte
   localparam logic [1:0] LANE_NONE = 2'b00;
   localparam logic [1:0] LANE_LO   = 2'b01;
   localparam logic [1:0] LANE_HI   = 2'b10;
   localparam logic [1:0] LANE_BOTH = 2'b11;

   // Lanes touched by a CPU access of the given width at the given byte offset
   function automatic logic [1:0] cpu_lanes(input logic wide, input logic lsb);
      return wide ? LANE_BOTH : (lsb ? LANE_LO : LANE_HI);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM port bundle for the memory arbiter
interface mem_arbiter_if #(
   parameter int AW = 15
);
   // video fetch port
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_gnt;
   logic          vid_rvalid;
   logic [15:0]   vid_rdata;
   // CPU port
   logic          cpu_en;
   logic          cpu_wr;
   logic          cpu_wide;
   logic [AW:0]   cpu_addr;
   logic [15:0]   cpu_din;
   logic [15:0]   cpu_dout;
   logic          cpu_ready;
   // DMA / loader port
   logic          dma_req;
   logic          dma_wr;
   logic [1:0]    dma_be;
   logic [AW-1:0] dma_addr;
   logic [15:0]   dma_wdata;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [15:0]   dma_rdata;
   // RAM port
   logic          mem_en;
   logic [1:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic [15:0]   mem_rdata;

   // Arbiter side
   modport slave (
      input  vid_req, vid_addr,
      output vid_gnt, vid_rvalid, vid_rdata,
      input  cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_din,
      output cpu_dout, cpu_ready,
      input  dma_req, dma_wr, dma_be, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Requesters and RAM side
   modport master (
      output vid_req, vid_addr,
      input  vid_gnt, vid_rvalid, vid_rdata,
      output cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_din,
      input  cpu_dout, cpu_ready,
      output dma_req, dma_wr, dma_be, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_arbiter_steer.sv
// rtl/mem_arbiter_steer.sv - CPU byte-lane steering for writes and read-data extraction
module mem_arbiter_steer
   import mem_arbiter_pkg::*;
(
   input  logic        i_wr,
   input  logic        i_wide,
   input  logic        i_lsb,
   input  logic [15:0] i_din,
   output logic [1:0]  o_we,
   output logic [15:0] o_wdata,
   input  logic        i_rsp_wide,
   input  logic        i_rsp_lsb,
   input  logic [15:0] i_rdata,
   output logic [15:0] o_dout
);

   // Request side: byte writes place din[7:0] on the lane selected by the byte address
   always_comb begin
      o_we = i_wr ? cpu_lanes(i_wide, i_lsb) : LANE_NONE;
      if (i_wide)
         o_wdata = i_din;
      else if (i_lsb)
         o_wdata = {8'h00, i_din[7:0]};
      else
         o_wdata = {i_din[7:0], 8'h00};
   end

   // Response side: uses the width/offset captured at grant, byte reads zero-extend
   always_comb begin
      if (i_rsp_wide)
         o_dout = i_rdata;
      else if (i_rsp_lsb)
         o_dout = {8'h00, i_rdata[7:0]};
      else
         o_dout = {8'h00, i_rdata[15:8]};
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter for video, CPU and DMA with CPU starvation guard
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW           = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   mem_arbiter_if.slave  io_bus
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] r_starve_cnt;
   owner_e        r_owner;
   logic          r_rsp_wide;
   logic          r_rsp_lsb;
   logic [AW-1:0] r_addr_hold;
   logic [15:0]   r_wdata_hold;

   logic          w_cpu_busy;
   logic          w_cpu_elig;
   logic          w_starved;
   logic          w_cpu_gnt;
   logic          w_vid_gnt;
   logic          w_dma_gnt;
   logic [1:0]    w_steer_we;
   logic [15:0]   w_steer_wdata;
   logic [15:0]   w_steer_dout;

   // The CPU stays busy for exactly the cycle its response is returned
   assign w_cpu_busy = (r_owner == OWN_CPU);
   assign w_cpu_elig = io_bus.cpu_en & ~w_cpu_busy;
   assign w_starved  = (r_starve_cnt == CW'(STARVE_LIMIT));

   // Grants are held off during reset so the RAM sees no strobe and all outputs read 0.
   // Normal order is video > CPU > DMA; a starved CPU jumps ahead of video for one slot.
   assign w_cpu_gnt = i_rst_n & w_cpu_elig & (w_starved | ~io_bus.vid_req);
   assign w_vid_gnt = i_rst_n & io_bus.vid_req & ~(w_cpu_elig & w_starved);
   assign w_dma_gnt = i_rst_n & io_bus.dma_req & ~io_bus.vid_req & ~w_cpu_elig;

   mem_arbiter_steer u_steer (
      .i_wr       (io_bus.cpu_wr),
      .i_wide     (io_bus.cpu_wide),
      .i_lsb      (io_bus.cpu_addr[0]),
      .i_din      (io_bus.cpu_din),
      .o_we       (w_steer_we),
      .o_wdata    (w_steer_wdata),
      .i_rsp_wide (r_rsp_wide),
      .i_rsp_lsb  (r_rsp_lsb),
      .i_rdata    (io_bus.mem_rdata),
      .o_dout     (w_steer_dout)
   );

   assign io_bus.vid_gnt = w_vid_gnt;
   assign io_bus.dma_gnt = w_dma_gnt;
   assign io_bus.mem_en  = w_cpu_gnt | w_vid_gnt | w_dma_gnt;

   // RAM port mux; address and write data hold their last value on idle cycles
   always_comb begin
      io_bus.mem_we    = LANE_NONE;
      io_bus.mem_addr  = r_addr_hold;
      io_bus.mem_wdata = r_wdata_hold;
      if (w_cpu_gnt) begin
         io_bus.mem_we    = w_steer_we;
         io_bus.mem_addr  = io_bus.cpu_addr[AW:1];
         io_bus.mem_wdata = w_steer_wdata;
      end else if (w_vid_gnt) begin
         io_bus.mem_addr  = io_bus.vid_addr;
      end else if (w_dma_gnt) begin
         io_bus.mem_we    = io_bus.dma_wr ? io_bus.dma_be : LANE_NONE;
         io_bus.mem_addr  = io_bus.dma_addr;
         io_bus.mem_wdata = io_bus.dma_wdata;
      end
   end

   // Count slots a ready CPU loses; restart whenever it is served or withdraws
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_starve_cnt <= '0;
      else if (!io_bus.cpu_en || w_cpu_gnt)
         r_starve_cnt <= '0;
      else if (w_cpu_elig && !w_starved)
         r_starve_cnt <= r_starve_cnt + CW'(1);
   end

   // Record who owns next cycle's RAM response; CPU writes still need a ready pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner    <= OWN_NONE;
         r_rsp_wide <= 1'b0;
         r_rsp_lsb  <= 1'b0;
      end else begin
         if (w_cpu_gnt)
            r_owner <= OWN_CPU;
         else if (w_vid_gnt)
            r_owner <= OWN_VID;
         else if (w_dma_gnt && !io_bus.dma_wr)
            r_owner <= OWN_DMA;
         else
            r_owner <= OWN_NONE;
         if (w_cpu_gnt) begin
            r_rsp_wide <= io_bus.cpu_wide;
            r_rsp_lsb  <= io_bus.cpu_addr[0];
         end
      end
   end

   // Keep the last driven RAM address/data so idle cycles do not toggle the bus
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr_hold  <= '0;
         r_wdata_hold <= '0;
      end else if (io_bus.mem_en) begin
         r_addr_hold  <= io_bus.mem_addr;
         r_wdata_hold <= io_bus.mem_wdata;
      end
   end

   assign io_bus.vid_rvalid = (r_owner == OWN_VID);
   assign io_bus.dma_rvalid = (r_owner == OWN_DMA);
   assign io_bus.cpu_ready  = (r_owner == OWN_CPU);
   assign io_bus.vid_rdata  = io_bus.vid_rvalid ? io_bus.mem_rdata : 16'h0000;
   assign io_bus.dma_rdata  = io_bus.dma_rvalid ? io_bus.mem_rdata : 16'h0000;
   assign io_bus.cpu_dout   = io_bus.cpu_ready  ? w_steer_dout     : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a byte-array reference
module tb_mem_arbiter;

   localparam int AW = 15;
   localparam int SL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(AW)) bus ();

   mem_arbiter #(.AW(AW), .STARVE_LIMIT(SL)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   // Behavioural synchronous RAM: read data one cycle after the strobe
   bit [15:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we[1]) ram[bus.mem_addr][15:8] <= bus.mem_wdata[15:8];
         if (bus.mem_we[0]) ram[bus.mem_addr][7:0]  <= bus.mem_wdata[7:0];
         bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   // Reference memory as a flat byte array; even byte is the high half of a word
   bit [7:0] ref_b [0:65535];

   function automatic logic [15:0] ref_word(input logic [14:0] w);
      return {ref_b[{w, 1'b0}], ref_b[{w, 1'b1}]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.vid_req = 0; bus.vid_addr = '0;
      bus.cpu_en = 0; bus.cpu_wr = 0; bus.cpu_wide = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
      bus.dma_req = 0; bus.dma_wr = 0; bus.dma_be = '0; bus.dma_addr = '0; bus.dma_wdata = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " vid_gnt"}, bus.vid_gnt, 0);
      chk({tag, " vid_rvalid"}, bus.vid_rvalid, 0);
      chk({tag, " vid_rdata"}, bus.vid_rdata, 0);
      chk({tag, " cpu_ready"}, bus.cpu_ready, 0);
      chk({tag, " cpu_dout"}, bus.cpu_dout, 0);
      chk({tag, " dma_gnt"}, bus.dma_gnt, 0);
      chk({tag, " dma_rvalid"}, bus.dma_rvalid, 0);
      chk({tag, " dma_rdata"}, bus.dma_rdata, 0);
      chk({tag, " mem_en"}, bus.mem_en, 0);
      chk({tag, " mem_we"}, bus.mem_we, 0);
      chk({tag, " mem_addr"}, bus.mem_addr, 0);
      chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
   endtask

   // CPU access issued alone; called just after a rising edge, returns just after one
   task automatic cpu_op(input bit wr, input bit wide, input logic [15:0] a,
                         input logic [15:0] d, input string tag);
      logic [1:0]  exp_we;
      logic [15:0] exp_wd;
      logic [15:0] exp_dout;
      if (wide) begin
         exp_we = wr ? 2'b11 : 2'b00; exp_wd = d; exp_dout = ref_word(a[15:1]);
      end else if (!a[0]) begin
         exp_we = wr ? 2'b10 : 2'b00; exp_wd = {d[7:0], 8'h00}; exp_dout = {8'h00, ref_b[a]};
      end else begin
         exp_we = wr ? 2'b01 : 2'b00; exp_wd = {8'h00, d[7:0]}; exp_dout = {8'h00, ref_b[a]};
      end
      bus.cpu_en = 1; bus.cpu_wr = wr; bus.cpu_wide = wide; bus.cpu_addr = a; bus.cpu_din = d;
      @(negedge clk);
      chk({tag, " mem_en"}, bus.mem_en, 1);
      chk({tag, " mem_we"}, bus.mem_we, exp_we);
      chk({tag, " mem_addr"}, bus.mem_addr, a[15:1]);
      if (wr) chk({tag, " mem_wdata"}, bus.mem_wdata, exp_wd);
      chk({tag, " ready early"}, bus.cpu_ready, 0);
      if (wr) begin
         if (wide) begin ref_b[{a[15:1], 1'b0}] = d[15:8]; ref_b[{a[15:1], 1'b1}] = d[7:0]; end
         else ref_b[a] = d[7:0];
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " cpu_ready"}, bus.cpu_ready, 1);
      chk({tag, " busy idle"}, bus.mem_en, 0);
      if (!wr) chk({tag, " cpu_dout"}, bus.cpu_dout, exp_dout);
      @(posedge clk); #1;
      bus.cpu_en = 0;
   endtask

   task automatic dma_op(input bit wr, input logic [1:0] be, input logic [14:0] w,
                         input logic [15:0] d, input string tag);
      logic [15:0] exp_rd;
      exp_rd = ref_word(w);
      bus.dma_req = 1; bus.dma_wr = wr; bus.dma_be = be; bus.dma_addr = w; bus.dma_wdata = d;
      @(negedge clk);
      chk({tag, " dma_gnt"}, bus.dma_gnt, 1);
      chk({tag, " mem_en"}, bus.mem_en, 1);
      chk({tag, " mem_we"}, bus.mem_we, wr ? be : 2'b00);
      chk({tag, " mem_addr"}, bus.mem_addr, w);
      if (wr) begin
         chk({tag, " mem_wdata"}, bus.mem_wdata, d);
         if (be[1]) ref_b[{w, 1'b0}] = d[15:8];
         if (be[0]) ref_b[{w, 1'b1}] = d[7:0];
      end
      @(posedge clk); #1;
      bus.dma_req = 0;
      @(negedge clk);
      chk({tag, " dma_rvalid"}, bus.dma_rvalid, !wr);
      if (!wr) chk({tag, " dma_rdata"}, bus.dma_rdata, exp_rd);
      @(posedge clk); #1;
   endtask

   task automatic vid_op(input logic [14:0] w, input string tag);
      bus.vid_req = 1; bus.vid_addr = w;
      @(negedge clk);
      chk({tag, " vid_gnt"}, bus.vid_gnt, 1);
      chk({tag, " mem_addr"}, bus.mem_addr, w);
      chk({tag, " mem_we"}, bus.mem_we, 0);
      @(posedge clk); #1;
      bus.vid_req = 0;
      @(negedge clk);
      chk({tag, " vid_rvalid"}, bus.vid_rvalid, 1);
      chk({tag, " vid_rdata"}, bus.vid_rdata, ref_word(w));
      @(posedge clk); #1;
   endtask

   initial begin
      idle_inputs();
      // reset state, including requests presented while reset is held
      @(negedge clk);
      chk_all_zero("reset");
      bus.vid_req = 1; bus.cpu_en = 1; bus.dma_req = 1;
      @(negedge clk);
      chk("reset gated mem_en", bus.mem_en, 0);
      chk("reset gated vid_gnt", bus.vid_gnt, 0);
      chk("reset gated dma_gnt", bus.dma_gnt, 0);
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // wide write then wide read
      cpu_op(1, 1, 16'hF000, 16'h1234, "t1 wr");
      cpu_op(0, 1, 16'hF000, 16'h0000, "t1 rd");
      chk("t1 value", bus.cpu_dout, 0);

      // byte write on the odd lane, then byte reads of both lanes
      cpu_op(1, 0, 16'hF001, 16'h00AB, "t2 wr");
      cpu_op(0, 0, 16'hF000, 16'h0000, "t2 rd even");
      cpu_op(0, 0, 16'hF001, 16'h0000, "t2 rd odd");

      // starvation: video every cycle, CPU held; CPU wins on slot index SL
      bus.vid_req = 1; bus.vid_addr = 15'h0123;
      bus.cpu_en = 1; bus.cpu_wr = 0; bus.cpu_wide = 1; bus.cpu_addr = 16'hF000;
      for (int c = 0; c <= SL + 1; c++) begin
         @(negedge clk);
         chk($sformatf("t3 vid_gnt c%0d", c), bus.vid_gnt, (c != SL));
         chk($sformatf("t3 mem_en c%0d", c), bus.mem_en, 1);
         if (c == SL) chk("t3 cpu addr", bus.mem_addr, 15'h7800);
         chk($sformatf("t3 cpu_ready c%0d", c), bus.cpu_ready, (c == SL + 1));
         if (c == SL + 1) chk("t3 cpu_dout", bus.cpu_dout, ref_word(15'h7800));
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;

      // all three request in the same cycle
      bus.vid_req = 1; bus.vid_addr = 15'h7800;
      bus.cpu_en = 1; bus.cpu_wr = 0; bus.cpu_wide = 1; bus.cpu_addr = 16'hF000;
      bus.dma_req = 1; bus.dma_wr = 0; bus.dma_addr = 15'h7800;
      @(negedge clk);
      chk("t4 c0 vid_gnt", bus.vid_gnt, 1);
      chk("t4 c0 dma_gnt", bus.dma_gnt, 0);
      @(posedge clk); #1;
      bus.vid_req = 0;
      @(negedge clk);
      chk("t4 c1 cpu mem_en", bus.mem_en, 1);
      chk("t4 c1 vid_gnt", bus.vid_gnt, 0);
      chk("t4 c1 dma_gnt", bus.dma_gnt, 0);
      chk("t4 c1 vid_rvalid", bus.vid_rvalid, 1);
      chk("t4 c1 vid_rdata", bus.vid_rdata, ref_word(15'h7800));
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4 c2 dma_gnt", bus.dma_gnt, 1);
      chk("t4 c2 cpu_ready", bus.cpu_ready, 1);
      chk("t4 c2 cpu_dout", bus.cpu_dout, ref_word(15'h7800));
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("t4 c3 dma_rvalid", bus.dma_rvalid, 1);
      chk("t4 c3 dma_rdata", bus.dma_rdata, ref_word(15'h7800));
      chk("t4 c3 idle", bus.mem_en, 0);
      @(posedge clk); #1;

      // DMA partial-lane write over a CPU word, then reads from both sides
      cpu_op(1, 1, 16'h1000, 16'h1234, "t5 cpu wr");
      dma_op(1, 2'b10, 15'h0800, 16'hFFFF, "t5 dma wr");
      dma_op(0, 2'b00, 15'h0800, 16'h0000, "t5 dma rd");
      cpu_op(0, 1, 16'h1000, 16'h0000, "t5 cpu rd");
      chk("t5 ref word", ref_word(15'h0800), 16'hFF34);
      dma_op(1, 2'b00, 15'h0800, 16'h5555, "t5 dma be0");
      vid_op(15'h0800, "t5 vid rd");

      // reset while a CPU read response is pending
      bus.cpu_en = 1; bus.cpu_wr = 0; bus.cpu_wide = 1; bus.cpu_addr = 16'hF000;
      @(negedge clk);
      chk("t6 grant", bus.mem_en, 1);
      rst_n = 0;
      #1;
      chk_all_zero("t6 in reset");
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6 no ready", bus.cpu_ready, 0);
      chk("t6 no mem_en", bus.mem_en, 0);
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      cpu_op(0, 1, 16'hF000, 16'h0000, "t6 after");

      // randomized single-requester traffic over a small shared window
      for (int i = 0; i < 60; i++) begin
         int unsigned kind;
         logic [15:0] d;
         logic [14:0] w;
         kind = $urandom_range(0, 2);
         d    = 16'($urandom);
         w    = 15'h1000 | 15'($urandom_range(0, 15));
         case (kind)
            0: cpu_op(1'($urandom), 1'($urandom), {w, 1'($urandom)}, d, $sformatf("rnd%0d cpu", i));
            1: dma_op(1'($urandom), 2'($urandom), w, d, $sformatf("rnd%0d dma", i));
            default: vid_op(w, $sformatf("rnd%0d vid", i));
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
